demux1x2_buf: RTL and testbench

- Buffered 1-to-2 steering block, the inverse of the 2x1 select mux: one 32-bit valid/ready source, two sinks.
- Each accepted word goes to output 1 or output 2, chosen by a per-word select bit, and is held in that output's FIFO until the sink takes it.
- Used on the datapath wherever one producer (e.g. memory response) must feed two consumers (e.g. fetch vs. load path) without stalling both on one slow sink.

---
 rtl/demux1x2_buf.sv | 94 +++++++++
 tb/tb_demux1x2_buf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_buf.sv
// Buffered 1-to-2 steering block: one valid/ready source feeds two sinks,
// each word is routed by its select bit into a per-output FIFO.
module demux1x2_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CW-1:0]    out1_count,
    output logic [CW-1:0]    out2_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem1 [DEPTH];
    logic [WIDTH-1:0] r_mem2 [DEPTH];
    logic [PW-1:0]    r_head1, r_tail1, r_head2, r_tail2;
    logic [CW-1:0]    r_count1, r_count2;

    logic w_full1, w_full2;
    logic w_push1, w_push2;
    logic w_pop1, w_pop2;

    // Ready looks only at the selected FIFO's registered count, never at the sinks.
    assign w_full1  = (r_count1 == CW'(DEPTH));
    assign w_full2  = (r_count2 == CW'(DEPTH));
    assign in_ready = ~flush & (in_sel ? ~w_full2 : ~w_full1);

    assign w_push1 = in_valid & in_ready & ~in_sel;
    assign w_push2 = in_valid & in_ready &  in_sel;

    assign out1_valid = (r_count1 != '0);
    assign out2_valid = (r_count2 != '0);
    assign w_pop1     = out1_valid & out1_ready;
    assign w_pop2     = out2_valid & out2_ready;

    // Data is forced to zero when empty so reset presents clean outputs.
    assign out1_data  = out1_valid ? r_mem1[r_head1] : '0;
    assign out2_data  = out2_valid ? r_mem2[r_head2] : '0;
    assign out1_count = r_count1;
    assign out2_count = r_count2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head1  <= '0;
            r_tail1  <= '0;
            r_count1 <= '0;
            r_head2  <= '0;
            r_tail2  <= '0;
            r_count2 <= '0;
        end else if (flush) begin
            r_head1  <= '0;
            r_tail1  <= '0;
            r_count1 <= '0;
            r_head2  <= '0;
            r_tail2  <= '0;
            r_count2 <= '0;
        end else begin
            if (w_push1) r_tail1 <= r_tail1 + PW'(1);
            if (w_pop1)  r_head1 <= r_head1 + PW'(1);
            if (w_push2) r_tail2 <= r_tail2 + PW'(1);
            if (w_pop2)  r_head2 <= r_head2 + PW'(1);
            case ({w_push1, w_pop1})
                2'b10:   r_count1 <= r_count1 + CW'(1);
                2'b01:   r_count1 <= r_count1 - CW'(1);
                default: r_count1 <= r_count1;
            endcase
            case ({w_push2, w_pop2})
                2'b10:   r_count2 <= r_count2 + CW'(1);
                2'b01:   r_count2 <= r_count2 - CW'(1);
                default: r_count2 <= r_count2;
            endcase
        end
    end

    // Storage has no reset; in_ready already excludes flush cycles.
    always_ff @(posedge clk) begin
        if (w_push1) r_mem1[r_tail1] <= in_data;
        if (w_push2) r_mem2[r_tail2] <= in_data;
    end

endmodule

// File: tb/tb_demux1x2_buf.sv
// Scoreboard bench for demux1x2_buf: accepted words queue per output,
// a monitor checks valid, count, head data and in_ready every cycle.
module tb_demux1x2_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [CW-1:0]    out1_count;
    logic [CW-1:0]    out2_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] q2 [$];

    demux1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out1_count (out1_count),
        .out2_count (out2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: compares the DUT against the queue model before the coming edge.
    always @(negedge clk) begin
        logic exp_rdy;
        int   sz;
        sz      = in_sel ? q2.size() : q1.size();
        exp_rdy = !flush && (sz != DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out1_count", 32'(out1_count), 32'(q1.size()));
        chk("out2_count", 32'(out2_count), 32'(q2.size()));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        chk("out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
        if (out1_valid === 1'b1 && q1.size() != 0) begin
            chk("out1_data", out1_data, q1[0]);
            if (out1_ready) void'(q1.pop_front());
        end
        if (out2_valid === 1'b1 && q2.size() != 0) begin
            chk("out2_data", out2_data, q2[0]);
            if (out2_ready) void'(q2.pop_front());
        end
    end

    // Recorder: each word the block accepts becomes an expected output.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (flush) begin
                q1.delete();
                q2.delete();
            end else if (in_valid && in_ready) begin
                if (in_sel) q2.push_back(in_data);
                else        q1.push_back(in_data);
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic r1, input logic r2, input logic fl);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out1_ready = r1;
        out2_ready = r2;
        flush      = fl;
    endtask

    task automatic push_until(input logic [31:0] d, input logic s,
                              input logic r1, input logic r2, input bit rnd);
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (rnd) drive(1'b1, s, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            else     drive(1'b1, s, d, r1, r2, 1'b0);
            #6;
            if (in_ready) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_timeout got=stalled exp=accept data=%h", d);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            if (q1.size() == 0 && q2.size() == 0) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=q1:%0d q2:%0d exp=0", q1.size(), q2.size());
        end
    endtask

    task automatic fill_both();
        drive(1'b1, 1'b0, 32'ha0a0_0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'ha0a0_0002, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'hb0b0_0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'hb0b0_0002, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #6;
        chk("fill_count1", 32'(out1_count), 32'(DEPTH));
        chk("fill_count2", 32'(out2_count), 32'(DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b1;
        flush      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out1_data", out1_data, 32'h0);
        chk("rst_out2_data", out2_data, 32'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle after reset, both select values.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        #6;
        chk("idle_ready_sel1", 32'(in_ready), 32'h1);

        // Basic steering.
        drive(1'b1, 1'b0, 32'h2cbd0b5d, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'hdcf83f6f, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #6;
        chk("steer_out2_data", out2_data, 32'hdcf83f6f);
        drain();

        // Backpressure on output 1; output 2 still accepts.
        drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h33, 1'b0, 1'b1, 1'b0);
        #6;
        chk("bp_ready_sel0", 32'(in_ready), 32'h0);
        chk("bp_count1", 32'(out1_count), 32'h2);
        drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
        #6;
        chk("bp_ready_sel1", 32'(in_ready), 32'h1);
        push_until(32'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        // Same-cycle push and pop on FIFO 2.
        drive(1'b1, 1'b1, 32'ha1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'ha2, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #6;
        chk("pp_count2", 32'(out2_count), 32'h1);
        chk("pp_out2_data", out2_data, 32'ha2);
        drain();

        // Pointer wrap with random sink readiness.
        for (int i = 0; i < 8; i++) push_until($urandom, 1'(i % 2), 1'b1, 1'b1, 1'b1);
        drain();

        // Flush with a concurrent push.
        fill_both();
        drive(1'b1, 1'b0, 32'hdead_beef, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #6;
        chk("flush_count1", 32'(out1_count), 32'h0);
        chk("flush_valid2", 32'(out2_valid), 32'h0);

        // Asynchronous reset between edges.
        fill_both();
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_valid1", 32'(out1_valid), 32'h0);
        chk("arst_valid2", 32'(out2_valid), 32'h0);
        chk("arst_count2", 32'(out2_count), 32'h0);
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
